cmn_bin2onehot_fifo: RTL and testbench

Buffered binary-index to one-hot decoder with valid/ready handshakes on both sides. It is the encode-side counterpart of the shared one-hot-to-binary converter. It sits between a producer of binary entry indices (e.g. PMP/arbiter pointer logic) and a consumer that needs one-hot select vectors. It decouples the two sides through a small FIFO and flags indices that cannot be represented in ONEHOT_WIDTH bits.

---
 rtl/cmn_bin2onehot_fifo.sv | 86 ++++++++
 tb/tb_cmn_bin2onehot_fifo.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cmn_bin2onehot_fifo.sv
// Buffered binary-index to one-hot decoder with valid/ready handshakes on both sides.
// Indices that do not fit in ONEHOT_WIDTH bits are flagged on out_err instead of decoded.
module cmn_bin2onehot_fifo #(
  parameter  int ONEHOT_WIDTH = 4,
  parameter  int DEPTH        = 2,
  localparam int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
  localparam int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [BIN_WIDTH-1:0]    in_bin,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [ONEHOT_WIDTH-1:0] out_onehot,
  output logic                    out_err,
  output logic [CNT_WIDTH-1:0]    count
);

  localparam int          PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] OH_LIM = ONEHOT_WIDTH;

  logic [BIN_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 push, pop;
  logic [BIN_WIDTH-1:0] head;

  // Explicit compare-and-wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign in_rdy  = (count_q < CNT_WIDTH'(DEPTH));
  assign out_vld = (count_q != '0);
  assign count   = count_q;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed through the out_vld gate.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= in_bin;
  end

  always_comb begin
    out_onehot = '0;
    for (int i = 0; i < ONEHOT_WIDTH; i++) begin
      if (out_vld && (head == BIN_WIDTH'(i))) out_onehot[i] = 1'b1;
    end
  end

  assign out_err = out_vld && (32'(head) >= OH_LIM);

endmodule

// File: tb/tb_cmn_bin2onehot_fifo.sv
// Randomized and directed checks of cmn_bin2onehot_fifo against a queue-based reference model,
// using a 4-wide/2-deep instance and a 5-wide/3-deep instance side by side.
module tb_cmn_bin2onehot_fifo;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       a_flush, a_in_vld, a_in_rdy, a_out_vld, a_out_rdy, a_out_err;
  logic [1:0] a_in_bin;
  logic [3:0] a_onehot;
  logic [1:0] a_count;

  logic       b_flush, b_in_vld, b_in_rdy, b_out_vld, b_out_rdy, b_out_err;
  logic [2:0] b_in_bin;
  logic [4:0] b_onehot;
  logic [1:0] b_count;

  cmn_bin2onehot_fifo #(.ONEHOT_WIDTH(4), .DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_vld(a_in_vld), .in_rdy(a_in_rdy), .in_bin(a_in_bin),
    .out_vld(a_out_vld), .out_rdy(a_out_rdy), .out_onehot(a_onehot),
    .out_err(a_out_err), .count(a_count)
  );

  cmn_bin2onehot_fifo #(.ONEHOT_WIDTH(5), .DEPTH(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_vld(b_in_vld), .in_rdy(b_in_rdy), .in_bin(b_in_bin),
    .out_vld(b_out_vld), .out_rdy(b_out_rdy), .out_onehot(b_onehot),
    .out_err(b_out_err), .count(b_count)
  );

  int qa[$];
  int qb[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_oh(input int n, input int h, input int w);
    if (n == 0 || h >= w) return 32'd0;
    return 32'd1 << h;
  endfunction

  task automatic check_outputs();
    int ha, hb;
    ha = (qa.size() != 0) ? qa[0] : 0;
    hb = (qb.size() != 0) ? qb[0] : 0;
    chk("a_count",   32'(a_count),   32'(qa.size()));
    chk("a_in_rdy",  32'(a_in_rdy),  32'(qa.size() < 2));
    chk("a_out_vld", 32'(a_out_vld), 32'(qa.size() != 0));
    chk("a_onehot",  32'(a_onehot),  exp_oh(qa.size(), ha, 4));
    chk("a_err",     32'(a_out_err), 32'(qa.size() != 0 && ha >= 4));
    chk("a_onehot0", 32'($onehot0(a_onehot)), 32'd1);
    chk("b_count",   32'(b_count),   32'(qb.size()));
    chk("b_in_rdy",  32'(b_in_rdy),  32'(qb.size() < 3));
    chk("b_out_vld", 32'(b_out_vld), 32'(qb.size() != 0));
    chk("b_onehot",  32'(b_onehot),  exp_oh(qb.size(), hb, 5));
    chk("b_err",     32'(b_out_err), 32'(qb.size() != 0 && hb >= 5));
    chk("b_onehot0", 32'($onehot0(b_onehot)), 32'd1);
  endtask

  // Called just after a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic tick();
    bit a_push, a_pop, b_push, b_pop, a_fl, b_fl;
    int a_d, b_d;
    check_outputs();
    a_push = a_in_vld && qa.size() < 2;
    a_pop  = a_out_rdy && qa.size() != 0;
    b_push = b_in_vld && qb.size() < 3;
    b_pop  = b_out_rdy && qb.size() != 0;
    a_fl = a_flush; b_fl = b_flush;
    a_d = int'(a_in_bin); b_d = int'(b_in_bin);
    @(posedge clk);
    if (a_fl) qa.delete();
    else begin
      if (a_pop)  void'(qa.pop_front());
      if (a_push) qa.push_back(a_d);
    end
    if (b_fl) qb.delete();
    else begin
      if (b_pop)  void'(qb.pop_front());
      if (b_push) qb.push_back(b_d);
    end
    @(negedge clk);
  endtask

  task automatic idle();
    a_flush = 0; a_in_vld = 0; a_in_bin = '0; a_out_rdy = 0;
    b_flush = 0; b_in_vld = 0; b_in_bin = '0; b_out_rdy = 0;
  endtask

  task automatic drain();
    a_in_vld = 0; b_in_vld = 0; a_out_rdy = 1; b_out_rdy = 1;
    for (int i = 0; i < 4; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // basic decode with immediate pop
    a_in_vld = 1; a_in_bin = 2; a_out_rdy = 1;
    tick();
    a_in_vld = 0;
    chk("basic_onehot", 32'(a_onehot), 32'h4);
    tick();
    tick();

    // full, backpressure, ordering
    a_out_rdy = 0; a_in_vld = 1;
    a_in_bin = 1; tick();
    a_in_bin = 3; tick();
    a_in_bin = 0; tick();
    chk("full_in_rdy", 32'(a_in_rdy), 32'd0);
    a_in_vld = 0; a_out_rdy = 1;
    chk("order_first", 32'(a_onehot), 32'h2);
    tick();
    chk("order_second", 32'(a_onehot), 32'h8);
    tick();
    tick();

    // steady streaming at count=1
    a_in_vld = 1; a_out_rdy = 1; a_in_bin = 0;
    tick();
    for (int i = 1; i < 10; i++) begin
      a_in_bin = 2'(i % 4);
      tick();
    end
    drain();

    // out-of-range decode and non-power-of-two wrap
    b_in_vld = 1; b_in_bin = 6; b_out_rdy = 0;
    tick();
    chk("oor_err", 32'(b_out_err), 32'd1);
    b_in_bin = 4; b_out_rdy = 1;
    tick();
    b_in_vld = 0;
    chk("oor_4", 32'(b_onehot), 32'h10);
    tick();
    for (int i = 0; i < 12; i++) begin
      b_in_vld = 1; b_in_bin = 3'(i % 8); b_out_rdy = (i % 3 != 0);
      tick();
    end
    drain();

    // flush with a concurrent push
    a_out_rdy = 0; a_in_vld = 1;
    a_in_bin = 1; tick();
    a_in_bin = 2; tick();
    a_flush = 1; a_in_bin = 3; a_out_rdy = 1;
    tick();
    a_flush = 0; a_in_vld = 0;
    chk("flush_count", 32'(a_count), 32'd0);
    tick();
    tick();

    // async reset with both FIFOs full
    a_out_rdy = 0; b_out_rdy = 0; a_in_vld = 1; b_in_vld = 1;
    for (int i = 0; i < 3; i++) begin
      a_in_bin = 2'(i + 1); b_in_bin = 3'(i + 2);
      tick();
    end
    a_in_vld = 0; b_in_vld = 0;
    #2 rst_n = 1'b0;
    #1;
    qa.delete(); qb.delete();
    chk("rst_in_rdy", 32'(a_in_rdy), 32'd1);
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    a_in_vld = 1; a_in_bin = 0; a_out_rdy = 0;
    tick();
    a_in_vld = 0;
    chk("post_rst_onehot", 32'(a_onehot), 32'h1);
    drain();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a_in_vld = 1'($urandom_range(0, 1)); a_in_bin = 2'($urandom);
      a_out_rdy = 1'($urandom_range(0, 1)); a_flush = ($urandom_range(0, 19) == 0);
      b_in_vld = 1'($urandom_range(0, 1)); b_in_bin = 3'($urandom);
      b_out_rdy = ($urandom_range(0, 2) != 0); b_flush = ($urandom_range(0, 19) == 0);
      tick();
    end
    idle();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
